imem_access_ctrl: RTL and testbench

// - Sequences the single-port synchronous instruction RAM (1-cycle read latency, cs/we/addr/wdata/rdata).
// - Serves IF-stage fetches with valid/ready handshakes and holds stalled responses.
// - Grants the program loader exclusive write access after in-flight fetches drain.
// - Sits between the IF stage, the loader and the instruction RAM instance.

---
 rtl/imem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_imem_access_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_ctrl.sv
// Instruction RAM sequencer: serves IF fetches, parks stalled responses, and hands the RAM
// to the program loader once in-flight fetches drain. Define IMEM_PERF_CNT_EN for perf counters.
module imem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [DATA_WIDTH-1:0] if_rsp_inst,
  input  logic                  ld_lock,
  output logic                  ld_grant,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic [31:0]           ld_req_addr,
  input  logic [3:0]            ld_req_we,
  input  logic [DATA_WIDTH-1:0] ld_req_wdata,
  output logic                  mem_cs,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef IMEM_PERF_CNT_EN
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`else
  input  logic [DATA_WIDTH-1:0] mem_rdata
`endif
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic                  issue_ok;
  logic                  fetch_fire;
  logic                  ld_ok;
  logic                  ld_fire;
  logic [ADDR_WIDTH-1:0] fetch_word;
  logic [ADDR_WIDTH-1:0] ld_word;

  // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
  assign fetch_word = if_req_addr[ADDR_WIDTH+1:2];
  assign ld_word    = ld_req_addr[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[1:0], if_req_addr[31:ADDR_WIDTH+2],
                              ld_req_addr[1:0], ld_req_addr[31:ADDR_WIDTH+2]};

  // A flush frees the response slot in the same cycle, so a redirect fetch can issue at once.
  always_comb begin
    issue_ok   = ~rst & (state_q == StRun) & ~ld_lock &
                 (if_flush | (~hold_valid_q & (~pend_q | if_rsp_ready)));
    fetch_fire = if_req_valid & issue_ok;
    ld_ok      = ~rst & (state_q == StLoad) & ld_lock;
    ld_fire    = ld_req_valid & ld_ok;
  end

  always_comb begin
    if_req_ready = issue_ok;
    ld_req_ready = ld_ok;
    ld_grant     = ~rst & (state_q == StLoad);
    if_rsp_valid = ~rst & (pend_q | hold_valid_q) & ~if_flush;
    if_rsp_inst  = '0;
    if (!rst) begin
      if_rsp_inst = hold_valid_q ? hold_data_q : mem_rdata;
    end
    mem_cs    = fetch_fire | ld_fire;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_fire) begin
      mem_we    = ld_req_we;
      mem_addr  = ld_word;
      mem_wdata = ld_req_wdata;
    end else if (fetch_fire) begin
      mem_addr = fetch_word;
    end
  end

  // RAM data is only valid for one cycle; park it if IF cannot take it.
  always_comb begin
    pend_d       = fetch_fire;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (hold_valid_q) begin
      if (if_rsp_ready || if_flush) begin
        hold_valid_d = 1'b0;
      end
    end else if (pend_q && !if_rsp_ready && !if_flush) begin
      hold_valid_d = 1'b1;
      hold_data_d  = mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (ld_lock) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!ld_lock) begin
          state_d = StRun;
        end else if (!pend_q && !hold_valid_q) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!ld_lock) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      pend_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_fire) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (if_req_valid && !issue_ok) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = rst ? 32'd0 : fetch_cnt_q;
  assign perf_stall_cnt = rst ? 32'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed scenarios plus random traffic checked per cycle
// against a transaction-level model (expected-response queue and shadow memory).
module tb_imem_access_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  localparam int ModeRun   = 0;
  localparam int ModeDrain = 1;
  localparam int ModeLoad  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [31:0]   if_req_addr;
  logic          if_flush;
  logic          if_rsp_valid;
  logic          if_rsp_ready;
  logic [DW-1:0] if_rsp_inst;
  logic          ld_lock;
  logic          ld_grant;
  logic          ld_req_valid;
  logic          ld_req_ready;
  logic [31:0]   ld_req_addr;
  logic [3:0]    ld_req_we;
  logic [DW-1:0] ld_req_wdata;
  logic          mem_cs;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
  int unsigned   exp_fetch_cnt;
  int unsigned   exp_stall_cnt;
`endif

  always #5 clk = ~clk;

  imem_access_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_inst  (if_rsp_inst),
    .ld_lock      (ld_lock),
    .ld_grant     (ld_grant),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_req_addr  (ld_req_addr),
    .ld_req_we    (ld_req_we),
    .ld_req_wdata (ld_req_wdata),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef IMEM_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[31:2]) % DEPTH;
  endfunction

  // Environment RAM: 1-cycle read latency, read data is garbage when no read was issued.
  logic [DW-1:0] ram [DEPTH];
  bit            ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (mem_cs && mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
    else                             mem_rdata <= $urandom;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: shadow memory, queue of owed instructions, loader mode.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  bit          fresh;
  int          mode;
  bit          exp_ready;
  bit          exp_ld_ready;
  bit          exp_fire;
  bit          exp_ld_fire;

  task automatic compare();
    bit busy;
    if (rst) begin
      check_eq("rst_ctrl", 64'({if_req_ready, if_rsp_valid, ld_grant, ld_req_ready, mem_cs,
                                mem_we, mem_addr}), 64'd0);
      check_eq("rst_inst", 64'(if_rsp_inst), 64'd0);
      check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
`ifdef IMEM_PERF_CNT_EN
      check_eq("rst_perf", {perf_fetch_cnt, perf_stall_cnt}, 64'd0);
`endif
      return;
    end
    busy         = exp_q.size() != 0;
    // A stalled (older) response blocks issue even when it is consumed this cycle.
    exp_ready    = mode == ModeRun && !ld_lock &&
                   (if_flush || !busy || (fresh && if_rsp_ready));
    exp_ld_ready = mode == ModeLoad && ld_lock;
    exp_fire     = if_req_valid && exp_ready;
    exp_ld_fire  = ld_req_valid && exp_ld_ready;
    check_eq("if_req_ready", 64'(if_req_ready), 64'(exp_ready));
    check_eq("if_rsp_valid", 64'(if_rsp_valid), 64'(busy && !if_flush));
    if (busy && !if_flush) check_eq("if_rsp_inst", 64'(if_rsp_inst), 64'(exp_q[0]));
    check_eq("ld_grant", 64'(ld_grant), 64'(mode == ModeLoad));
    check_eq("ld_req_ready", 64'(ld_req_ready), 64'(exp_ld_ready));
    check_eq("mem_cs", 64'(mem_cs), 64'(exp_fire || exp_ld_fire));
    if (exp_ld_fire) begin
      check_eq("ld_mem_we", 64'(mem_we), 64'(ld_req_we));
      check_eq("ld_mem_addr", 64'(mem_addr), 64'(widx(ld_req_addr)));
      check_eq("ld_mem_wdata", 64'(mem_wdata), 64'(ld_req_wdata));
    end else if (exp_fire) begin
      check_eq("if_mem_we", 64'(mem_we), 64'd0);
      check_eq("if_mem_addr", 64'(mem_addr), 64'(widx(if_req_addr)));
    end
`ifdef IMEM_PERF_CNT_EN
    check_eq("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(exp_fetch_cnt));
    check_eq("perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall_cnt));
`endif
  endtask

  task automatic model_update();
    bit had;
    int w;
    if (rst) begin
      exp_q.delete();
      fresh = 1'b0;
      mode  = ModeRun;
`ifdef IMEM_PERF_CNT_EN
      exp_fetch_cnt = 0;
      exp_stall_cnt = 0;
`endif
      return;
    end
    had = exp_q.size() != 0;
    if (had && (if_flush || if_rsp_ready)) exp_q.delete();
    fresh = 1'b0;
    if (exp_fire) begin
      exp_q.push_back(ref_mem[widx(if_req_addr)]);
      fresh = 1'b1;
    end
    if (exp_ld_fire) begin
      w = widx(ld_req_addr);
      for (int b = 0; b < 4; b++) begin
        if (ld_req_we[b]) ref_mem[w][b*8 +: 8] = ld_req_wdata[b*8 +: 8];
      end
    end
`ifdef IMEM_PERF_CNT_EN
    if (exp_fire) exp_fetch_cnt++;
    if (if_req_valid && !exp_ready) exp_stall_cnt++;
`endif
    case (mode)
      ModeRun:   if (ld_lock) mode = ModeDrain;
      ModeDrain: if (!ld_lock) mode = ModeRun; else if (!had) mode = ModeLoad;
      default:   if (!ld_lock) mode = ModeRun;
    endcase
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    mode = ModeRun;
    fresh = 1'b0;
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0; if_rsp_ready = 1'b0;
    ld_lock = 1'b0; ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_we = '0; ld_req_wdata = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Back-to-back fetches with IF always ready.
    if_rsp_ready = 1'b1;
    for (int a = 0; a < 3; a++) begin
      if_req_valid = 1'b1; if_req_addr = 32'(a * 4);
      tick();
    end
    if_req_valid = 1'b0;
    tick(); tick();

    // Stalled response held for three cycles, then released.
    if_req_valid = 1'b1; if_req_addr = 32'h4; if_rsp_ready = 1'b0;
    tick();
    if_req_addr = 32'h8;
    repeat (3) tick();
    if_rsp_ready = 1'b1;
    tick(); tick();
    if_req_valid = 1'b0;
    tick(); tick();

    // Flush with a redirect fetch in the same cycle.
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    tick();
    if_flush = 1'b1; if_req_addr = 32'h20;
    tick();
    if_flush = 1'b0; if_req_valid = 1'b0;
    #1 check_eq("flush_new_path", 64'(if_rsp_inst), 64'(init_word(8)));
    tick();

    // Lock with a held response: drain, load one word, unlock, read it back.
    if_req_valid = 1'b1; if_req_addr = 32'hC; if_rsp_ready = 1'b0;
    tick();
    if_req_valid = 1'b0;
    tick();
    ld_lock = 1'b1;
    tick(); tick();
    #1 check_eq("drain_no_grant", 64'(ld_grant), 64'd0);
    if_rsp_ready = 1'b1;
    tick(); tick();
    ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_we = 4'hF; ld_req_wdata = 32'hDEADBEEF;
    #1 check_eq("load_grant", 64'(ld_grant), 64'd1);
    tick();
    ld_req_valid = 1'b0; ld_lock = 1'b0;
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    tick();
    if_req_valid = 1'b0;
    #1 check_eq("load_readback", 64'(if_rsp_inst), 64'h0000_0000_DEAD_BEEF);
    tick();

    // Reset while draining with a held response.
    if_req_valid = 1'b1; if_req_addr = 32'h14; if_rsp_ready = 1'b0;
    tick();
    if_req_valid = 1'b0;
    tick();
    ld_lock = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ld_lock = 1'b0;
    #1 check_eq("post_rst_quiet", 64'({if_rsp_valid, ld_grant}), 64'd0);
    tick();
    if_rsp_ready = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h0;
    tick();
    if_req_valid = 1'b0;
    #1 check_eq("post_rst_word0", 64'(if_rsp_inst), 64'(init_word(0)));
    tick();

    // Random traffic over a small window so loader writes get fetched back.
    for (int n = 0; n < 3000; n++) begin
      rst          = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 39) == 0) ld_lock = ~ld_lock;
      if_req_valid = $urandom_range(0, 9) < 7;
      if_req_addr  = $urandom & 32'hF000_00FF;
      if_rsp_ready = $urandom_range(0, 9) < 7;
      if_flush     = $urandom_range(0, 14) == 0;
      ld_req_valid = $urandom_range(0, 1) == 1;
      ld_req_addr  = $urandom & 32'hF000_00FF;
      ld_req_we    = 4'($urandom_range(0, 15));
      ld_req_wdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
